// File: rtl/signed_sat_acc_pkg.sv
// Shared types and constants for the signed saturating frame accumulator.
//   acc_state_t : frame FSM state (ACCUM collects samples, HOLD presents the result)
//   IN_W        : width of the signed sample coming from the upstream adder
package signed_sat_acc_pkg;

  typedef enum logic {ACCUM, HOLD} acc_state_t;

  localparam int IN_W = 4;

endpackage

// File: rtl/sat_add.sv
// Signed W-bit adder with overflow detect; clamps or wraps on overflow.
// Build option: SIGNED_SAT_ACC_SATURATE_EN defined -> clamp to the signed
// W-bit range on overflow; undefined -> wrap modulo 2^W.
// Ports:
//   a, b : signed W-bit operands
//   sum  : signed W-bit result (clamped or wrapped)
//   ovf  : operands share a sign and the W-bit result sign differs
module sat_add #(
  parameter int W = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  logic signed [W:0] ext_sum;

  assign ext_sum = {a[W-1], a} + {b[W-1], b};

  // The W+1-bit sum is exact; its top two bits disagree exactly when the
  // W-bit result has a sign different from two same-signed operands.
  assign ovf = ext_sum[W] ^ ext_sum[W-1];

`ifdef SIGNED_SAT_ACC_SATURATE_EN
  always_comb begin
    sum = ext_sum[W-1:0];
    if (ovf) begin
      sum = ext_sum[W] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign sum = ext_sum[W-1:0];
`endif

endmodule

// File: rtl/signed_sat_accumulator.sv
// Frame accumulator sitting behind the 4-bit signed adder stage. Sums N
// accepted samples into a signed W-bit register (clamp or wrap on overflow),
// then holds the frame total until downstream takes it.
// Build option: SIGNED_SAT_ACC_SATURATE_EN selects clamping (see sat_add).
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   up_vld/up_rdy   : upstream handshake
//   up_sum, up_ovf  : signed sample and the adder's overflow flag
//   down_vld/down_rdy : downstream handshake
//   down_acc        : signed frame total
//   down_ovf        : accumulator overflowed at least once in the frame
//   down_in_ovf_cnt : accepted samples in the frame that had up_ovf set
//
// state | meaning
// ACCUM | accepting samples, up_rdy high
// HOLD  | frame complete, result presented on down_*, upstream stalled
module signed_sat_accumulator
  import signed_sat_acc_pkg::*;
#(
  parameter  int W  = 8,
  parameter  int N  = 4,
  localparam int CW = $clog2(N+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                up_vld,
  output logic                up_rdy,
  input  logic [IN_W-1:0]     up_sum,
  input  logic                up_ovf,
  output logic                down_vld,
  input  logic                down_rdy,
  output logic signed [W-1:0] down_acc,
  output logic                down_ovf,
  output logic [CW-1:0]       down_in_ovf_cnt
);

  acc_state_t         state_q, state_d;
  logic signed [W-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      ovf_cnt_q, ovf_cnt_d;
  logic               frame_ovf_q, frame_ovf_d;

  logic signed [W-1:0] sample_ext;
  logic signed [W-1:0] add_sum;
  logic                add_ovf;
  logic                accept;

  assign sample_ext = {{(W-IN_W){up_sum[IN_W-1]}}, up_sum};

  sat_add #(.W(W)) u_sat_add (
    .a   (acc_q),
    .b   (sample_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign up_rdy          = (state_q == ACCUM);
  assign down_vld        = (state_q == HOLD);
  assign down_acc        = acc_q;
  assign down_ovf        = frame_ovf_q;
  assign down_in_ovf_cnt = ovf_cnt_q;

  assign accept = up_vld & up_rdy;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_cnt_d   = ovf_cnt_q;
    frame_ovf_d = frame_ovf_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d       = add_sum;
          cnt_d       = cnt_q + CW'(1);
          ovf_cnt_d   = ovf_cnt_q + CW'(up_ovf);
          frame_ovf_d = frame_ovf_q | add_ovf;
          if (cnt_q == CW'(N-1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (down_rdy) begin
          acc_d       = '0;
          cnt_d       = '0;
          ovf_cnt_d   = '0;
          frame_ovf_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_cnt_q   <= '0;
      frame_ovf_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
      frame_ovf_q <= frame_ovf_d;
    end
  end

endmodule

// File: tb/tb_signed_sat_accumulator.sv
module tb_signed_sat_accumulator;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_vld;
  logic [3:0] up_sum;
  logic       up_ovf;
  logic       down_rdy;

  logic              up_rdy8, down_vld8, down_ovf8;
  logic signed [7:0] down_acc8;
  logic [2:0]        down_cnt8;
  logic              up_rdy5, down_vld5, down_ovf5;
  logic signed [4:0] down_acc5;
  logic [2:0]        down_cnt5;

  signed_sat_accumulator #(.W(8), .N(N)) dut8 (
    .clk(clk), .rst(rst), .up_vld(up_vld), .up_rdy(up_rdy8),
    .up_sum(up_sum), .up_ovf(up_ovf), .down_vld(down_vld8),
    .down_rdy(down_rdy), .down_acc(down_acc8), .down_ovf(down_ovf8),
    .down_in_ovf_cnt(down_cnt8)
  );

  signed_sat_accumulator #(.W(5), .N(N)) dut5 (
    .clk(clk), .rst(rst), .up_vld(up_vld), .up_rdy(up_rdy5),
    .up_sum(up_sum), .up_ovf(up_ovf), .down_vld(down_vld5),
    .down_rdy(down_rdy), .down_acc(down_acc5), .down_ovf(down_ovf5),
    .down_in_ovf_cnt(down_cnt5)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: frame contents as plain integers
  bit m_hold;
  int m_cnt, m_icnt;
  int m_acc8, m_acc5;
  bit m_fovf8, m_fovf5;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_add(input int acc, input int s, input int w, output bit ev);
    int t, mx, mn;
    t  = acc + s;
    mx = (1 << (w-1)) - 1;
    mn = -(1 << (w-1));
    ev = (t > mx) || (t < mn);
    if (ev) begin
`ifdef SIGNED_SAT_ACC_SATURATE_EN
      t = (t > mx) ? mx : mn;
`else
      if (t > mx) t = t - (1 << w);
      else        t = t + (1 << w);
`endif
    end
    return t;
  endfunction

  task automatic model_reset();
    m_hold = 0; m_cnt = 0; m_icnt = 0;
    m_acc8 = 0; m_acc5 = 0; m_fovf8 = 0; m_fovf5 = 0;
  endtask

  task automatic model_step(input bit vld, input int s, input bit ov, input bit rdy);
    bit e;
    if (!m_hold) begin
      if (vld) begin
        m_acc8 = ref_add(m_acc8, s, 8, e); m_fovf8 |= e;
        m_acc5 = ref_add(m_acc5, s, 5, e); m_fovf5 |= e;
        m_cnt++;
        m_icnt += int'(ov);
        if (m_cnt == N) m_hold = 1;
      end
    end else if (rdy) begin
      model_reset();
    end
  endtask

  task automatic compare_all();
    chk("up_rdy8",   int'(up_rdy8),   int'(!m_hold));
    chk("up_rdy5",   int'(up_rdy5),   int'(!m_hold));
    chk("down_vld8", int'(down_vld8), int'(m_hold));
    chk("down_vld5", int'(down_vld5), int'(m_hold));
    chk("acc8",      int'(down_acc8), m_acc8);
    chk("acc5",      int'(down_acc5), m_acc5);
    chk("fovf8",     int'(down_ovf8), int'(m_fovf8));
    chk("fovf5",     int'(down_ovf5), int'(m_fovf5));
    chk("icnt8",     int'(down_cnt8), m_icnt);
    chk("icnt5",     int'(down_cnt5), m_icnt);
  endtask

  // inputs change at the negedge, DUT samples at posedge, outputs checked next negedge
  task automatic step(input bit vld, input int s, input bit ov, input bit rdy);
    up_vld   = vld;
    up_sum   = s[3:0];
    up_ovf   = ov;
    down_rdy = rdy;
    model_step(vld, s, ov, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  int t1_s[4] = '{3, 4, -2, 5};
  int t2_s[4] = '{7, 7, 7, -8};
  int t3_s[4] = '{-8, -8, 1, 1};
  bit t3_o[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  bit t6_v[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int hold_acc, s;
    rst = 1'b0; up_vld = 0; up_sum = '0; up_ovf = 0; down_rdy = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b1;

    // 1: plain frame, down_vld for exactly one cycle
    foreach (t1_s[i]) step(1, t1_s[i], 0, 1);
    chk("t1_vld", int'(down_vld8), 1);
    chk("t1_acc", int'(down_acc8), 10);
    chk("t1_ovf", int'(down_ovf8), 0);
    step(1, 6, 0, 1);
    chk("t1_vld_drop", int'(down_vld8), 0);

    // 2: overflow behaviour at W=5
    foreach (t2_s[i]) step(1, t2_s[i], 0, 1);
`ifdef SIGNED_SAT_ACC_SATURATE_EN
    chk("t2_acc5", int'(down_acc5), 7);
`else
    chk("t2_acc5", int'(down_acc5), 13);
`endif
    chk("t2_ovf5", int'(down_ovf5), 1);
    step(0, 0, 0, 1);

    // 3: adder-flagged inputs counted, used as received
    foreach (t3_s[i]) step(1, t3_s[i], t3_o[i], 1);
    chk("t3_acc8", int'(down_acc8), -14);
    chk("t3_icnt", int'(down_cnt8), 2);
    step(0, 0, 0, 1);

    // 4: backpressure with upstream still offering data
    for (int i = 0; i < 4; i++) step(1, i + 1, 0, 0);
    hold_acc = int'(down_acc8);
    chk("t4_acc_start", hold_acc, 10);
    for (int i = 0; i < 5; i++) begin
      step(1, 7, 1, 0);
      chk("t4_stable", int'(down_acc8), hold_acc);
      chk("t4_stall", int'(up_rdy8), 0);
    end
    step(1, 7, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1);
    chk("t4_next_acc", int'(down_acc8), 4);
    step(0, 0, 0, 1);

    // 5: asynchronous reset mid-frame
    step(1, 3, 1, 1);
    step(1, 3, 0, 1);
    rst = 1'b0;
    #1;
    model_reset();
    chk("t5_acc", int'(down_acc8), 0);
    chk("t5_rdy", int'(up_rdy8), 1);
    chk("t5_icnt", int'(down_cnt8), 0);
    compare_all();
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1);
    chk("t5_acc_after", int'(down_acc8), 4);
    step(0, 0, 0, 1);

    // 6: bubbles between accepts
    foreach (t6_v[i]) step(t6_v[i], t6_v[i] ? 2 : -5, 0, 1);
    chk("t6_vld", int'(down_vld8), 1);
    chk("t6_acc", int'(down_acc8), 8);
    step(0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      s = int'($urandom_range(15)) - 8;
      step(($urandom_range(3) != 0), s, $urandom_range(1) == 1, ($urandom_range(2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
